// File: rtl/data_sync_pkg.sv
// Shared defaults for the data_sync CDC slice.
package data_sync_pkg;
    localparam int unsigned DEF_NUM_STAGES = 2;
    localparam int unsigned DEF_BUS_WIDTH  = 8;
endpackage

// File: rtl/data_sync_bit_sync.sv
// NUM_STAGES-deep single-bit flop synchronizer into the CLK domain.
module bit_sync
    import data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_async,
    output logic o_sync
);

    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Multi-bit CDC receiver: synchronizes the enable, edge-detects it and
// captures the (stable) source bus on that single-cycle pulse.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse
);

    localparam logic [BUS_WIDTH-1:0] BUS_RST = '0;

    logic                 w_sync_en;
    logic                 w_pulse;
    logic                 r_hist;
    logic [BUS_WIDTH-1:0] r_sync_bus;
    logic                 r_enable_pulse;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (bus_enable),
        .o_sync  (w_sync_en)
    );

    // Rising edge only: a held enable yields one capture per assertion.
    assign w_pulse = w_sync_en & ~r_hist;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hist         <= 1'b0;
            r_sync_bus     <= BUS_RST;
            r_enable_pulse <= 1'b0;
        end else begin
            r_hist         <= w_sync_en;
            r_enable_pulse <= w_pulse;
            if (w_pulse) begin
                r_sync_bus <= unsync_bus;
            end
        end
    end

    assign sync_bus     = r_sync_bus;
    assign enable_pulse = r_enable_pulse;

endmodule

// File: tb/tb_data_sync.sv
// Directed self-checking bench for data_sync (default and 3-stage/16-bit builds).
module tb_data_sync;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  bus_a;
    logic        en_a;
    logic [7:0]  sync_a;
    logic        pulse_a;
    logic [15:0] bus_b;
    logic        en_b;
    logic [15:0] sync_b;
    logic        pulse_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    data_sync #(
        .NUM_STAGES (2),
        .BUS_WIDTH  (8)
    ) dut_a (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (bus_a),
        .bus_enable   (en_a),
        .sync_bus     (sync_a),
        .enable_pulse (pulse_a)
    );

    data_sync #(
        .NUM_STAGES (3),
        .BUS_WIDTH  (16)
    ) dut_b (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (bus_b),
        .bus_enable   (en_b),
        .sync_bus     (sync_b),
        .enable_pulse (pulse_b)
    );

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST   = 1'b0;
        bus_a = 8'hFF;
        en_a  = 1'b1;
        bus_b = 16'hFFFF;
        en_b  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (sync_a !== 8'h00) $display("FAIL reset_sync_bus cyc%0d: got %h want 00", i, sync_a);
            else n_pass++;
            n_total++;
            if (pulse_a !== 1'b0) $display("FAIL reset_pulse cyc%0d: got %b want 0", i, pulse_a);
            else n_pass++;
            tick();
        end
        n_total++;
        if (sync_b !== 16'h0000 || pulse_b !== 1'b0)
            $display("FAIL reset_dut_b: got %h/%b want 0000/0", sync_b, pulse_b);
        else n_pass++;
        en_a = 1'b0;
        tick();
        RST = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_single_transfer();
        bus_a = 8'hAB;
        en_a  = 1'b1;
        tick();
        tick();
        n_total++;
        if (pulse_a !== 1'b0 || sync_a !== 8'h00)
            $display("FAIL single_early edge2: got %h/%b want 00/0", sync_a, pulse_a);
        else n_pass++;
        tick();
        n_total++;
        if (pulse_a !== 1'b1) $display("FAIL single_pulse edge3: got %b want 1", pulse_a);
        else n_pass++;
        n_total++;
        if (sync_a !== 8'hAB) $display("FAIL single_data edge3: got %h want ab", sync_a);
        else n_pass++;
        tick();
        n_total++;
        if (pulse_a !== 1'b0) $display("FAIL single_pulse_end edge4: got %b want 0", pulse_a);
        else n_pass++;
        n_total++;
        if (sync_a !== 8'hAB) $display("FAIL single_hold edge4: got %h want ab", sync_a);
        else n_pass++;
    endtask

    task automatic test_enable_held();
        int pulses = 0;
        bus_a = 8'hCD;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(pulse_a);
        end
        bus_a = 8'hEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(pulse_a);
        end
        n_total++;
        if (pulses != 0) $display("FAIL held_pulses: got %0d want 0", pulses);
        else n_pass++;
        n_total++;
        if (sync_a !== 8'hAB) $display("FAIL held_data: got %h want ab", sync_a);
        else n_pass++;
    endtask

    task automatic test_rearm();
        int pulses = 0;
        en_a = 1'b0;
        repeat (4) tick();
        bus_a = 8'hCD;
        en_a  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            pulses += int'(pulse_a);
            if (i == 3) begin
                n_total++;
                if (pulse_a !== 1'b1 || sync_a !== 8'hCD)
                    $display("FAIL rearm_capture edge3: got %h/%b want cd/1", sync_a, pulse_a);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 1) $display("FAIL rearm_pulse_count: got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int pulses = 0;
        en_a = 1'b0;
        repeat (4) tick();
        bus_a = 8'h5A;
        en_a  = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        n_total++;
        if (sync_a !== 8'h00 || pulse_a !== 1'b0)
            $display("FAIL midreset_clear: got %h/%b want 00/0", sync_a, pulse_a);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(pulse_a);
        end
        n_total++;
        if (pulses != 0 || sync_a !== 8'h00)
            $display("FAIL midreset_hold: got %h pulses %0d want 00 pulses 0", sync_a, pulses);
        else n_pass++;
        RST = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            pulses += int'(pulse_a);
            if (i == 3) begin
                n_total++;
                if (pulse_a !== 1'b1 || sync_a !== 8'h5A)
                    $display("FAIL midreset_recover edge3: got %h/%b want 5a/1", sync_a, pulse_a);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 1) $display("FAIL midreset_pulse_count: got %0d want 1", pulses);
        else n_pass++;
        en_a = 1'b0;
    endtask

    task automatic test_param_sweep();
        int pulses = 0;
        bus_b = 16'hBEEF;
        en_b  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            pulses += int'(pulse_b);
            if (i == 3) begin
                n_total++;
                if (pulse_b !== 1'b0 || sync_b !== 16'h0000)
                    $display("FAIL sweep_early edge3: got %h/%b want 0000/0", sync_b, pulse_b);
                else n_pass++;
            end
            if (i == 4) begin
                n_total++;
                if (pulse_b !== 1'b1 || sync_b !== 16'hBEEF)
                    $display("FAIL sweep_capture edge4: got %h/%b want beef/1", sync_b, pulse_b);
                else n_pass++;
            end
            if (i == 5) begin
                n_total++;
                if (pulse_b !== 1'b0 || sync_b !== 16'hBEEF)
                    $display("FAIL sweep_after edge5: got %h/%b want beef/0", sync_b, pulse_b);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 1) $display("FAIL sweep_pulse_count: got %0d want 1", pulses);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_transfer();
        test_enable_held();
        test_rearm();
        test_reset_midflight();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Clock-domain-crossing synchronizer for a multi-bit data bus qualified by a single enable bit.
- Only bus_enable passes through an NUM_STAGES-deep flop synchronizer. Its rising edge produces a one-cycle pulse.
- That pulse captures unsync_bus, which is stable at that point, into a destination-domain register. A registered one-cycle enable_pulse is also emitted.
- Sits at the receive side of any crossing between an unrelated source domain and the CLK domain.

Parameters:
- NUM_STAGES, 2, depth of the enable synchronizer flop chain; legal range is 2 or more.
- BUS_WIDTH, 8, width of the data bus in bits.

Ports:
- CLK  input  1  destination-domain clock; all state updates on its rising edge.
- RST  input  1  asynchronous active-low reset.
- unsync_bus  input  BUS_WIDTH  data from the source domain; stable while bus_enable is asserted.
- bus_enable  input  1  source-domain data-valid level, asynchronous to CLK.
- sync_bus  output  BUS_WIDTH  registered, synchronized copy of unsync_bus.
- enable_pulse  output  1  registered one-CLK-cycle strobe, high in the cycle sync_bus takes new data.

Behaviour:
- Reset (RST=0, asynchronous, overrides the clock):
  - all synchronizer stages = 0, pulse-gen history flop = 0, sync_bus = 0, enable_pulse = 0.
  - Reset asserted mid-operation clears everything immediately; any in-flight enable is discarded.
- Synchronizer: a shift chain of NUM_STAGES flops. Stage 0 samples bus_enable; stage k samples stage k-1. sync_en is the last stage.
- Pulse generator:
  - a history flop samples sync_en each cycle.
  - pulse_comb = sync_en AND NOT history (rising-edge detect only).
- Data mux/register, each clock:
  - sync_bus <= pulse_comb ? unsync_bus : sync_bus (hold otherwise).
  - enable_pulse <= pulse_comb.
- Latency: bus_enable rises before edge E0. Stage 0 goes high at E0 and sync_en at E(NUM_STAGES-1). sync_bus and enable_pulse update at E(NUM_STAGES).
  - For NUM_STAGES=2, outputs change on the 3rd rising edge after bus_enable goes high.
- enable_pulse is high for exactly one CLK cycle per rising edge of bus_enable, regardless of how long bus_enable stays high.
- bus_enable held high: no further pulses. Changes on unsync_bus are ignored and sync_bus holds its value.
- bus_enable low: nothing is captured.
- A new rising edge is recognised only after sync_en has been observed low for at least one cycle.
- bus_enable pulses shorter than one CLK period may be missed. This is legal and must not corrupt sync_bus.
- unsync_bus is never passed through synchronizer flops; correctness relies on the source holding it stable from the bus_enable assertion until enable_pulse.

Decomposition:
- No shared package is required. Reset values (all zeros) are local constants.
- One natural sub-module: bit_sync, a parameterised NUM_STAGES-deep single-bit synchronizer with CLK and RST.
  - It is instantiated once for bus_enable.
  - Pulse generator and data register stay in data_sync.

Test Plan:
- Reset: RST=0 for one cycle with unsync_bus=0xFF and bus_enable=1 -> sync_bus=0x00 and enable_pulse=0 while RST=0. Both stay 0 for the full reset duration.
- Single transfer, NUM_STAGES=2: after reset, set unsync_bus=0xAB and bus_enable=1 just after a rising edge. Required response:
  - sync_bus=0xAB and enable_pulse=1 after the 3rd rising edge.
  - enable_pulse=0 after the 4th edge.
  - sync_bus stays 0xAB thereafter.
- Enable held high: continue the previous case, change unsync_bus to 0xCD, wait 10 cycles, then to 0xEF with bus_enable still 1 -> no further enable_pulse; sync_bus remains 0xAB.
- Re-arm: drop bus_enable for 3 or more cycles, then raise it with unsync_bus=0xCD -> exactly one enable_pulse; sync_bus=0xCD at NUM_STAGES+1 edges after the rise.
- Reset mid-flight: raise bus_enable with data 0x5A, then assert RST one edge later -> sync_bus=0x00 and no pulse. After release with bus_enable still high, one pulse appears and sync_bus=0x5A.
- Parameter sweep: NUM_STAGES=3 and BUS_WIDTH=16, data 0xBEEF -> capture and pulse occur on the 4th edge after bus_enable rises.
